cnn_frame_loader: RTL and testbench

// UART-side command/frame engine for the CNN accelerator, sitting between uart_rx and the image RAMs / cnn core.

---
 rtl/cnn_frame_loader_pkg.sv | 39 +++
 rtl/cnn_frame_loader_timeout.sv | 30 +++
 rtl/cnn_frame_loader.sv | 189 ++++++++++++++++++
 tb/tb_cnn_frame_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_frame_loader_pkg.sv
// Shared types and constants for the CNN frame loader: FSM encodings,
// command bytes and the layout of the status reply byte.
package cnn_frame_loader_pkg;

   typedef enum logic [1:0] {
      L_IDLE = 2'd0,
      L_DATA = 2'd1,
      L_CSUM = 2'd2
   } load_state_t;

   typedef enum logic [1:0] {
      J_IDLE  = 2'd0,
      J_RUN   = 2'd1,
      J_REPLY = 2'd2
   } job_state_t;

   localparam logic [7:0] CMD_LOAD  = 8'h67;
   localparam logic [7:0] CMD_RUN   = 8'h64;
   localparam logic [7:0] CMD_STAT  = 8'h73;
   localparam logic [7:0] REPLY_ERR = 8'h45;
   localparam logic [3:0] STAT_TAG  = 4'hA;

   localparam int STAT_BUSY = 0;
   localparam int STAT_IMG  = 1;
   localparam int STAT_CSUM = 2;
   localparam int STAT_TMO  = 3;

   function automatic logic [7:0] status_byte(input logic tmo, input logic csum,
                                              input logic img, input logic busy);
      logic [7:0] s;
      s            = {STAT_TAG, 4'h0};
      s[STAT_TMO]  = tmo;
      s[STAT_CSUM] = csum;
      s[STAT_IMG]  = img;
      s[STAT_BUSY] = busy;
      return s;
   endfunction

endpackage

// File: rtl/cnn_frame_loader_timeout.sv
// Inter-byte watchdog: expires after TIMEOUT_CYC consecutive enabled cycles
// without a load; a load in the same cycle always wins over expiry.
module frame_timeout_counter #(
   parameter int TIMEOUT_CYC = 18000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable && count != LAST) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && !load && (count == LAST);

endmodule

// File: rtl/cnn_frame_loader.sv
// UART command/frame engine: loads frames into a ping-pong image bank while the
// cnn runs on the last committed bank, and returns result/status bytes to TX.
module cnn_frame_loader
   import cnn_frame_loader_pkg::*;
#(
   parameter int         IMG_BYTES   = 784,
   parameter int         ADDR_W      = 10,
   parameter int         RES_W       = 4,
   parameter int         TIMEOUT_CYC = 18000,
   parameter int         CSUM_EN     = 1,
   parameter logic [7:0] RES_BASE    = 8'h30
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              rd_bank,
   output logic              cnn_rst,
   input  logic              cnn_finish,
   input  logic [RES_W-1:0]  cnn_result,
   output logic [RES_W-1:0]  result,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output load_state_t       l_state_dbg,
   output job_state_t        j_state_dbg
);

   load_state_t       l_state;
   job_state_t        j_state;
   logic [ADDR_W-1:0] cnt;
   logic [7:0]        sum;
   logic [7:0]        res_byte;
   logic              has_img, err_tmo, err_csum, commit_pend;
   logic              stat_pend, res_sent, tx_is_res;

   logic l_idle, cmd_load, cmd_run, cmd_stat;
   logic data_byte, last_byte, csum_byte, csum_bad, commit_evt, commit_now;
   logic rd_bank_nx, tmo_exp, tx_free, res_load, stat_load, tx_done_res;

   // Bytes are commands only while the loader is idle; inside a frame they are data.
   assign l_idle      = (l_state == L_IDLE);
   assign cmd_load    = rx_ready && l_idle && (rx_data == CMD_LOAD);
   assign cmd_run     = rx_ready && l_idle && (rx_data == CMD_RUN) && (j_state == J_IDLE);
   assign cmd_stat    = rx_ready && l_idle && (rx_data == CMD_STAT);
   assign data_byte   = rx_ready && (l_state == L_DATA);
   assign last_byte   = data_byte && (cnt == ADDR_W'(IMG_BYTES - 1));
   assign csum_byte   = rx_ready && (l_state == L_CSUM);
   assign csum_bad    = csum_byte && (rx_data != sum);
   assign commit_evt  = (last_byte && CSUM_EN == 0) || (csum_byte && rx_data == sum);
   // The bank under the cnn stays put while it runs; a finished frame waits.
   assign commit_now  = (commit_evt || commit_pend) && (j_state != J_RUN);
   assign rd_bank_nx  = commit_now ? wr_bank : rd_bank;

   assign tx_free     = !tx_valid;
   assign res_load    = tx_free && (j_state == J_REPLY) && !res_sent;
   assign stat_load   = tx_free && !res_load && (stat_pend || cmd_stat);
   assign tx_done_res = tx_valid && tx_ready && tx_is_res;

   assign busy        = (j_state != J_IDLE);
   assign l_state_dbg = l_state;
   assign j_state_dbg = j_state;

   frame_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (rx_ready),
      .enable  (!l_idle),
      .expired (tmo_exp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_state <= L_IDLE;
         cnt     <= '0;
         sum     <= '0;
         wr_en   <= 1'b0;
         wr_bank <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= 1'b0;
         case (l_state)
            L_IDLE: begin
               if (cmd_load) begin
                  l_state <= L_DATA;
                  cnt     <= '0;
                  sum     <= '0;
                  wr_bank <= ~rd_bank_nx;
               end
            end
            L_DATA: begin
               if (tmo_exp) begin
                  l_state <= L_IDLE;
               end else if (data_byte) begin
                  wr_en   <= 1'b1;
                  wr_addr <= cnt;
                  wr_data <= rx_data;
                  sum     <= sum + rx_data;
                  cnt     <= cnt + 1'b1;
                  if (last_byte) l_state <= (CSUM_EN != 0) ? L_CSUM : L_IDLE;
               end
            end
            L_CSUM: begin
               if (tmo_exp || csum_byte) l_state <= L_IDLE;
            end
            default: l_state <= L_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j_state     <= J_IDLE;
         cnn_rst     <= 1'b1;
         result      <= '0;
         res_byte    <= '0;
         res_sent    <= 1'b0;
         rd_bank     <= 1'b0;
         has_img     <= 1'b0;
         commit_pend <= 1'b0;
         err_tmo     <= 1'b0;
         err_csum    <= 1'b0;
         stat_pend   <= 1'b0;
         tx_valid    <= 1'b0;
         tx_data     <= '0;
         tx_is_res   <= 1'b0;
      end else begin
         if (commit_now) begin
            rd_bank <= wr_bank;
            has_img <= 1'b1;
         end
         // A new frame supersedes one still waiting to be committed.
         commit_pend <= (commit_evt || commit_pend) && !commit_now && !cmd_load;
         err_csum    <= (err_csum && !stat_load) || csum_bad;
         err_tmo     <= (err_tmo && !stat_load) || tmo_exp;
         stat_pend   <= (stat_pend || cmd_stat) && !stat_load;

         case (j_state)
            J_IDLE: begin
               if (cmd_run) begin
                  if (has_img) begin
                     j_state <= J_RUN;
                     cnn_rst <= 1'b0;
                  end else begin
                     res_byte <= REPLY_ERR;
                     j_state  <= J_REPLY;
                  end
               end
            end
            J_RUN: begin
               if (cnn_finish) begin
                  result   <= cnn_result;
                  res_byte <= RES_BASE + 8'(cnn_result);
                  cnn_rst  <= 1'b1;
                  j_state  <= J_REPLY;
               end
            end
            J_REPLY: begin
               if (tx_done_res) begin
                  j_state  <= J_IDLE;
                  res_sent <= 1'b0;
               end else if (res_load) begin
                  res_sent <= 1'b1;
               end
            end
            default: j_state <= J_IDLE;
         endcase

         if (res_load) begin
            tx_valid  <= 1'b1;
            tx_data   <= res_byte;
            tx_is_res <= 1'b1;
         end else if (stat_load) begin
            tx_valid  <= 1'b1;
            tx_data   <= status_byte(err_tmo, err_csum, has_img, j_state != J_IDLE);
            tx_is_res <= 1'b0;
         end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Bench for cnn_frame_loader: scenario tasks against a frame/status/reply model.
module tb_cnn_frame_loader;
   import cnn_frame_loader_pkg::*;

   localparam int IMG = 784;
   localparam int AW  = 10;
   localparam int RW  = 4;
   localparam int TMO = 18000;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic rx_ready = 1'b0, cnn_finish = 1'b0, tx_ready = 1'b0;
   logic [RW-1:0] cnn_result = '0;
   logic wr_en, wr_bank, rd_bank, cnn_rst, tx_valid, busy;
   logic [AW-1:0] wr_addr;
   logic [7:0] wr_data, tx_data;
   logic [RW-1:0] result;
   load_state_t l_state_dbg;
   job_state_t  j_state_dbg;

   int checks = 0, failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [AW+8:0] wr_q[$];
   logic [7:0] frame[IMG];
   bit tx_hold = 1'b0;

   bit m_rd_bank, m_has_img, m_err_tmo, m_err_csum;

   always #5 clk = ~clk;

   cnn_frame_loader dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_bank(rd_bank), .cnn_rst(cnn_rst), .cnn_finish(cnn_finish),
      .cnn_result(cnn_result), .result(result), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
      .l_state_dbg(l_state_dbg), .j_state_dbg(j_state_dbg)
   );

   // TX sink and RAM write monitor, both sampled on the falling edge.
   always @(negedge clk) begin
      tx_ready = !tx_hold && ($urandom_range(0, 3) != 0);
      if (tx_valid && tx_ready && rst_n) got_q.push_back(tx_data);
      if (wr_en) wr_q.push_back({wr_bank, wr_addr, wr_data});
   end

   function automatic logic [7:0] exp_status();
      return {4'hA, m_err_tmo, m_err_csum, m_has_img, 1'b0};
   endfunction

   function automatic logic [7:0] frame_sum();
      int s = 0;
      for (int i = 0; i < IMG; i++) s += int'(frame[i]);
      return 8'(s % 256);
   endfunction

   function automatic int first_bad_write(input logic bank, input int n);
      if (wr_q.size() != n) return -2;
      for (int i = 0; i < n; i++)
         if (wr_q[i] !== {bank, AW'(i), frame[i]}) return i;
      return -1;
   endfunction

   task automatic make_frame(input bit ramp);
      for (int i = 0; i < IMG; i++) frame[i] = ramp ? 8'(i) : 8'($urandom_range(0, 255));
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b; rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
   endtask

   task automatic send_frame(input int n);
      for (int i = 0; i < n; i++) send_byte(frame[i]);
   endtask

   task automatic get_tx(output logic [7:0] b, output bit ok);
      ok = 1'b0; b = '0;
      for (int i = 0; i < 3000; i++) begin
         if (got_q.size() > 0) begin
            b = got_q.pop_front(); ok = 1'b1; break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_cnn_rst(input logic level, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (cnn_rst === level) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic model_reset();
      m_rd_bank = 0; m_has_img = 0; m_err_tmo = 0; m_err_csum = 0;
      exp_q.delete(); got_q.delete(); wr_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({wr_en, wr_bank, rd_bank, cnn_rst, tx_valid, busy} !== 6'b000100) begin
         failures++; $display("FAIL reset_flags: got %b want 000100", {wr_en, wr_bank, rd_bank, cnn_rst, tx_valid, busy});
      end
      checks++;
      if ({wr_addr, wr_data, tx_data, result} !== '0) begin
         failures++; $display("FAIL reset_buses: addr %h wdata %h tx %h res %h want 0", wr_addr, wr_data, tx_data, result);
      end
      checks++;
      if (l_state_dbg !== L_IDLE || j_state_dbg !== J_IDLE) begin
         failures++; $display("FAIL reset_states: got %0d/%0d want 0/0", l_state_dbg, j_state_dbg);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_run_no_img();
      logic [7:0] b, exp; bit ok;
      send_byte(CMD_RUN); exp_q.push_back(REPLY_ERR);
      get_tx(b, ok); exp = exp_q.pop_front(); checks++;
      if (!ok || b !== exp) begin
         failures++; $display("FAIL run_no_img: got %h (ok=%0d) want %h", b, ok, exp);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || result !== '0) begin
         failures++; $display("FAIL run_no_img_idle: busy %b result %h want 0/0", busy, result);
      end
   endtask

   task automatic test_bad_csum();
      logic [7:0] b, exp; bit ok; int idx;
      make_frame(1'b1); wr_q.delete();
      send_byte(CMD_LOAD); send_frame(IMG); send_byte(frame_sum() ^ 8'hFF);
      repeat (3) @(negedge clk);
      idx = first_bad_write(~m_rd_bank, IMG); checks++;
      if (idx != -1) begin
         failures++; $display("FAIL bad_csum_writes: first bad index %0d (size %0d) want -1", idx, wr_q.size());
      end
      m_err_csum = 1'b1; checks++;
      if (rd_bank !== m_rd_bank) begin
         failures++; $display("FAIL bad_csum_rd_bank: got %b want %b", rd_bank, m_rd_bank);
      end
      for (int k = 0; k < 2; k++) begin
         send_byte(CMD_STAT); exp_q.push_back(exp_status()); m_err_tmo = 0; m_err_csum = 0;
         get_tx(b, ok); exp = exp_q.pop_front(); checks++;
         if (!ok || b !== exp) begin
            failures++; $display("FAIL bad_csum_status%0d: got %h (ok=%0d) want %h", k, b, ok, exp);
         end
      end
   endtask

   task automatic test_good_load();
      logic [7:0] b, exp; bit ok; int idx;
      make_frame(1'b1); wr_q.delete();
      send_byte(CMD_LOAD); send_frame(IMG); send_byte(frame_sum());
      repeat (3) @(negedge clk);
      idx = first_bad_write(~m_rd_bank, IMG); checks++;
      if (idx != -1) begin
         failures++; $display("FAIL good_load_writes: first bad index %0d (size %0d) want -1", idx, wr_q.size());
      end
      m_rd_bank = ~m_rd_bank; m_has_img = 1'b1; checks++;
      if (rd_bank !== m_rd_bank) begin
         failures++; $display("FAIL good_load_rd_bank: got %b want %b", rd_bank, m_rd_bank);
      end
      send_byte(CMD_STAT); exp_q.push_back(exp_status());
      get_tx(b, ok); exp = exp_q.pop_front(); checks++;
      if (!ok || b !== exp) begin
         failures++; $display("FAIL good_load_status: got %h (ok=%0d) want %h", b, ok, exp);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] b, exp; bit ok; int idx;
      make_frame(1'b0); wr_q.delete();
      send_byte(CMD_LOAD); send_frame(100);
      repeat (TMO + 50) @(negedge clk);
      m_err_tmo = 1'b1; checks++;
      if (wr_q.size() != 100 || rd_bank !== m_rd_bank || l_state_dbg !== L_IDLE) begin
         failures++; $display("FAIL timeout_abort: writes %0d rd_bank %b lstate %0d want 100/%b/0", wr_q.size(), rd_bank, l_state_dbg, m_rd_bank);
      end
      send_byte(CMD_STAT); exp_q.push_back(exp_status()); m_err_tmo = 0; m_err_csum = 0;
      get_tx(b, ok); exp = exp_q.pop_front(); checks++;
      if (!ok || b !== exp) begin
         failures++; $display("FAIL timeout_status: got %h (ok=%0d) want %h", b, ok, exp);
      end
      // Two long gaps inside one frame: each is under the limit, together they exceed it.
      make_frame(1'b0); wr_q.delete();
      send_byte(CMD_LOAD);
      for (int i = 0; i < IMG; i++) begin
         if (i == 200 || i == 500) repeat (TMO * 3 / 4) @(negedge clk);
         send_byte(frame[i]);
      end
      send_byte(frame_sum());
      repeat (3) @(negedge clk);
      idx = first_bad_write(~m_rd_bank, IMG); checks++;
      if (idx != -1) begin
         failures++; $display("FAIL timeout_restart_writes: first bad index %0d (size %0d) want -1", idx, wr_q.size());
      end
      m_rd_bank = ~m_rd_bank; checks++;
      if (rd_bank !== m_rd_bank) begin
         failures++; $display("FAIL timeout_restart_rd_bank: got %b want %b", rd_bank, m_rd_bank);
      end
   endtask

   task automatic test_run();
      logic [7:0] b, exp; bit ok; logic [RW-1:0] r;
      for (int k = 0; k < 2; k++) begin
         r = (k == 0) ? RW'(7) : RW'($urandom_range(0, 9));
         send_byte(CMD_RUN); wait_cnn_rst(1'b0, ok); checks++;
         if (!ok || busy !== 1'b1) begin
            failures++; $display("FAIL run_start%0d: cnn_rst low %0d busy %b want 1/1", k, ok, busy);
         end
         repeat ($urandom_range(5, 40)) @(negedge clk);
         cnn_finish = 1'b1; cnn_result = r;
         @(negedge clk); cnn_finish = 1'b0;
         exp_q.push_back(RES_W_BASE(r));
         get_tx(b, ok); exp = exp_q.pop_front(); checks++;
         if (!ok || b !== exp || result !== r || cnn_rst !== 1'b1) begin
            failures++; $display("FAIL run_reply%0d: tx %h (ok=%0d) result %h cnn_rst %b want %h/%h/1", k, b, ok, result, cnn_rst, exp, r);
         end
      end
   endtask

   function automatic logic [7:0] RES_W_BASE(input logic [RW-1:0] r);
      return 8'h30 + 8'(r);
   endfunction

   task automatic test_load_during_run();
      logic [7:0] b, exp; bit ok; int idx; logic [RW-1:0] r;
      send_byte(CMD_RUN); wait_cnn_rst(1'b0, ok);
      make_frame(1'b0); wr_q.delete();
      send_byte(CMD_LOAD); send_frame(IMG); send_byte(frame_sum());
      repeat (5) @(negedge clk);
      idx = first_bad_write(~m_rd_bank, IMG); checks++;
      if (!ok || idx != -1) begin
         failures++; $display("FAIL run_load_writes: run %0d first bad index %0d want 1/-1", ok, idx);
      end
      checks++;
      if (rd_bank !== m_rd_bank || cnn_rst !== 1'b0) begin
         failures++; $display("FAIL run_load_deferred: rd_bank %b cnn_rst %b want %b/0", rd_bank, cnn_rst, m_rd_bank);
      end
      r = RW'($urandom_range(0, 9));
      cnn_finish = 1'b1; cnn_result = r;
      @(negedge clk); cnn_finish = 1'b0;
      exp_q.push_back(RES_W_BASE(r)); m_rd_bank = ~m_rd_bank;
      get_tx(b, ok); exp = exp_q.pop_front(); checks++;
      if (!ok || b !== exp || rd_bank !== m_rd_bank) begin
         failures++; $display("FAIL run_load_commit: tx %h (ok=%0d) rd_bank %b want %h/%b", b, ok, rd_bank, exp, m_rd_bank);
      end
      // cnn_finish lands in the same cycle as a frame byte.
      repeat (3) @(negedge clk);
      send_byte(CMD_RUN); wait_cnn_rst(1'b0, ok);
      make_frame(1'b0); wr_q.delete(); r = RW'($urandom_range(0, 9));
      send_byte(CMD_LOAD);
      for (int i = 0; i < IMG; i++) begin
         @(negedge clk);
         rx_data = frame[i]; rx_ready = 1'b1;
         if (i == 300) begin cnn_finish = 1'b1; cnn_result = r; end
         @(negedge clk);
         rx_ready = 1'b0; cnn_finish = 1'b0;
      end
      send_byte(frame_sum());
      repeat (3) @(negedge clk);
      idx = first_bad_write(~m_rd_bank, IMG); checks++;
      if (!ok || idx != -1) begin
         failures++; $display("FAIL coincident_writes: run %0d first bad index %0d want 1/-1", ok, idx);
      end
      exp_q.push_back(RES_W_BASE(r)); m_rd_bank = ~m_rd_bank;
      get_tx(b, ok); exp = exp_q.pop_front(); checks++;
      if (!ok || b !== exp || result !== r || rd_bank !== m_rd_bank) begin
         failures++; $display("FAIL coincident_reply: tx %h (ok=%0d) result %h rd_bank %b want %h/%h/%b", b, ok, result, rd_bank, exp, r, m_rd_bank);
      end
   endtask

   task automatic test_tx_stall();
      logic [7:0] b, exp; bit ok; int bad; logic [RW-1:0] r;
      tx_hold = 1'b1; r = RW'($urandom_range(0, 9));
      send_byte(CMD_RUN); wait_cnn_rst(1'b0, ok);
      cnn_finish = 1'b1; cnn_result = r;
      @(negedge clk); cnn_finish = 1'b0;
      exp_q.push_back(RES_W_BASE(r));
      send_byte(CMD_STAT); exp_q.push_back(exp_status());
      send_byte(CMD_STAT);
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0 || got_q.size() != 0) begin
         failures++; $display("FAIL tx_stall_hold: unstable cycles %0d early bytes %0d want 0/0", bad, got_q.size());
      end
      tx_hold = 1'b0;
      for (int k = 0; k < 2; k++) begin
         get_tx(b, ok); exp = exp_q.pop_front(); checks++;
         if (!ok || b !== exp) begin
            failures++; $display("FAIL tx_stall_byte%0d: got %h (ok=%0d) want %h", k, b, ok, exp);
         end
      end
      repeat (100) @(negedge clk);
      checks++;
      if (got_q.size() != 0) begin
         failures++; $display("FAIL tx_stall_dup_status: extra bytes %0d want 0", got_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b, exp; bit ok;
      make_frame(1'b0);
      send_byte(CMD_LOAD); send_frame(50);
      @(negedge clk); rst_n = 1'b0; #1;
      checks++;
      if ({wr_en, rd_bank, cnn_rst, tx_valid, busy} !== 5'b00100 || l_state_dbg !== L_IDLE) begin
         failures++; $display("FAIL mid_reset_values: got %b lstate %0d want 00100/0", {wr_en, rd_bank, cnn_rst, tx_valid, busy}, l_state_dbg);
      end
      repeat (2) @(negedge clk);
      model_reset(); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send_byte(CMD_STAT); exp_q.push_back(exp_status());
      get_tx(b, ok); exp = exp_q.pop_front(); checks++;
      if (!ok || b !== exp) begin
         failures++; $display("FAIL mid_reset_status: got %h (ok=%0d) want %h", b, ok, exp);
      end
      send_byte(CMD_RUN); exp_q.push_back(REPLY_ERR);
      get_tx(b, ok); exp = exp_q.pop_front(); checks++;
      if (!ok || b !== exp) begin
         failures++; $display("FAIL mid_reset_no_img: got %h (ok=%0d) want %h", b, ok, exp);
      end
   endtask

   initial begin
      test_reset();
      test_run_no_img();
      test_bad_csum();
      test_good_load();
      test_timeout();
      test_run();
      test_load_during_run();
      test_tx_stall();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
